// File: rtl/shot_arbiter.sv
`default_nettype none
// ============================================================================
// shot_arbiter : battleship turn sequencer, board owner and shot resolver
// Optional build macro: BONUS_TURN_EN (a non-final hit keeps the turn)
// Revision: 1.0
// ============================================================================
module shot_arbiter #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  localparam int RW  = $clog2(ROWS),
  localparam int CLW = $clog2(COLS),
  localparam int NW  = $clog2(ROWS*COLS+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_place_we,
  input  logic           i_place_board,
  input  logic [RW-1:0]  i_place_row,
  input  logic [CLW-1:0] i_place_col,
  input  logic           i_start,
  input  logic           i_p_req,
  input  logic [RW-1:0]  i_p_row,
  input  logic [CLW-1:0] i_p_col,
  input  logic           i_pc_req,
  input  logic [RW-1:0]  i_pc_row,
  input  logic [CLW-1:0] i_pc_col,
  input  logic           i_turn_expired,
  output logic           o_p_ack,
  output logic           o_pc_ack,
  output logic           o_res_valid,
  output logic           o_res_hit,
  output logic           o_res_repeat,
  output logic           o_res_err,
  output logic           o_res_who,
  output logic           o_turn,
  output logic [NW-1:0]  o_p_left,
  output logic [NW-1:0]  o_pc_left,
  output logic           o_game_over,
  output logic           o_winner,
  input  logic           i_disp_board,
  input  logic [RW-1:0]  i_disp_row,
  input  logic [CLW-1:0] i_disp_col,
  output logic [1:0]     o_disp_cell
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam logic [RW:0]  c_rows  = (RW+1)'(ROWS);
  localparam logic [CLW:0] c_cols  = (CLW+1)'(COLS);
  localparam logic [1:0]   c_water = 2'b00;
  localparam logic [1:0]   c_ship  = 2'b01;
  localparam logic [1:0]   c_miss  = 2'b10;
  localparam logic [1:0]   c_hit   = 2'b11;

  typedef enum logic [2:0] {
    S_LOAD, S_WAIT_P, S_RD_P, S_WR_P, S_WAIT_PC, S_RD_PC, S_WR_PC, S_OVER
  } state_t;

  function automatic logic in_rng(input logic [RW-1:0] r, input logic [CLW-1:0] c);
    return ({1'b0, r} < c_rows) && ({1'b0, c} < c_cols);
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r, input logic [CLW-1:0] c);
    return IW'(r) * IW'(COLS) + IW'(c);
  endfunction

  state_t         r_state;
  logic [1:0]     r_pb [CELLS];
  logic [1:0]     r_cb [CELLS];
  logic [RW-1:0]  r_row;
  logic [CLW-1:0] r_col;
  logic [1:0]     r_cell;
  logic           r_oor;

  logic           w_place_ok;
  logic [IW-1:0]  w_place_idx;
  logic [1:0]     w_place_old;
  logic           w_shot_ok;
  logic [IW-1:0]  w_shot_idx;
  logic [1:0]     w_p_cell;
  logic [1:0]     w_c_cell;
  logic           w_disp_ok;
  logic [IW-1:0]  w_disp_idx;

  assign w_place_ok  = in_rng(i_place_row, i_place_col);
  assign w_place_idx = cell_idx(i_place_row, i_place_col);
  assign w_shot_ok   = in_rng(r_row, r_col);
  assign w_shot_idx  = cell_idx(r_row, r_col);
  assign w_disp_ok   = in_rng(i_disp_row, i_disp_col);
  assign w_disp_idx  = cell_idx(i_disp_row, i_disp_col);

  // Every array read is muxed off when its coordinates fall outside the board.
  always_comb begin
    w_place_old = c_water;
    w_p_cell    = c_water;
    w_c_cell    = c_water;
    o_disp_cell = c_water;
    if (w_place_ok)
      w_place_old = i_place_board ? r_cb[w_place_idx] : r_pb[w_place_idx];
    if (w_shot_ok) begin
      w_p_cell = r_pb[w_shot_idx];
      w_c_cell = r_cb[w_shot_idx];
    end
    if (w_disp_ok)
      o_disp_cell = i_disp_board ? r_cb[w_disp_idx] : r_pb[w_disp_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
      for (int i = 0; i < CELLS; i++) begin
        r_pb[i] <= c_water;
        r_cb[i] <= c_water;
      end
      r_row        <= '0;
      r_col        <= '0;
      r_cell       <= c_water;
      r_oor        <= 1'b0;
      o_p_ack      <= 1'b0;
      o_pc_ack     <= 1'b0;
      o_res_valid  <= 1'b0;
      o_res_hit    <= 1'b0;
      o_res_repeat <= 1'b0;
      o_res_err    <= 1'b0;
      o_res_who    <= 1'b0;
      o_turn       <= 1'b0;
      o_p_left     <= '0;
      o_pc_left    <= '0;
      o_game_over  <= 1'b0;
      o_winner     <= 1'b0;
    end else begin
      o_p_ack      <= 1'b0;
      o_pc_ack     <= 1'b0;
      o_res_valid  <= 1'b0;
      o_res_hit    <= 1'b0;
      o_res_repeat <= 1'b0;
      o_res_err    <= 1'b0;
      o_res_who    <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (i_place_we && w_place_ok) begin
            if (i_place_board) begin
              r_cb[w_place_idx] <= c_ship;
              if (w_place_old == c_water) o_pc_left <= o_pc_left + NW'(1);
            end else begin
              r_pb[w_place_idx] <= c_ship;
              if (w_place_old == c_water) o_p_left <= o_p_left + NW'(1);
            end
          end
          if (i_start && (o_p_left != '0) && (o_pc_left != '0)) begin
            r_state <= S_WAIT_P;
            o_turn  <= 1'b0;
          end
        end
        S_WAIT_P: begin
          if (i_p_req) begin
            r_row   <= i_p_row;
            r_col   <= i_p_col;
            r_state <= S_RD_P;
          end else if (i_turn_expired) begin
            r_state <= S_WAIT_PC;
            o_turn  <= 1'b1;
          end
        end
        // Result flags are registered here so they appear with the ack in WR.
        S_RD_P: begin
          r_cell       <= w_c_cell;
          r_oor        <= !w_shot_ok;
          o_p_ack      <= 1'b1;
          o_res_valid  <= 1'b1;
          o_res_who    <= 1'b0;
          o_res_err    <= !w_shot_ok;
          o_res_repeat <= w_shot_ok && w_c_cell[1];
          o_res_hit    <= w_shot_ok && (w_c_cell == c_ship);
          r_state      <= S_WR_P;
        end
        S_WR_P: begin
          if (r_oor) begin
            r_state <= S_WAIT_P;
          end else if (r_cell == c_ship) begin
            r_cb[w_shot_idx] <= c_hit;
            if (o_pc_left != '0) o_pc_left <= o_pc_left - NW'(1);
            if (o_pc_left < NW'(2)) begin
              r_state     <= S_OVER;
              o_game_over <= 1'b1;
              o_winner    <= 1'b0;
            end else begin
`ifdef BONUS_TURN_EN
              r_state <= S_WAIT_P;
`else
              r_state <= S_WAIT_PC;
              o_turn  <= 1'b1;
`endif
            end
          end else begin
            if (r_cell == c_water) r_cb[w_shot_idx] <= c_miss;
            r_state <= S_WAIT_PC;
            o_turn  <= 1'b1;
          end
        end
        S_WAIT_PC: begin
          if (i_pc_req) begin
            r_row   <= i_pc_row;
            r_col   <= i_pc_col;
            r_state <= S_RD_PC;
          end else if (i_turn_expired) begin
            r_state <= S_WAIT_P;
            o_turn  <= 1'b0;
          end
        end
        S_RD_PC: begin
          r_cell       <= w_p_cell;
          r_oor        <= !w_shot_ok;
          o_pc_ack     <= 1'b1;
          o_res_valid  <= 1'b1;
          o_res_who    <= 1'b1;
          o_res_err    <= !w_shot_ok;
          o_res_repeat <= w_shot_ok && w_p_cell[1];
          o_res_hit    <= w_shot_ok && (w_p_cell == c_ship);
          r_state      <= S_WR_PC;
        end
        S_WR_PC: begin
          if (r_oor) begin
            r_state <= S_WAIT_PC;
          end else if (r_cell == c_ship) begin
            r_pb[w_shot_idx] <= c_hit;
            if (o_p_left != '0) o_p_left <= o_p_left - NW'(1);
            if (o_p_left < NW'(2)) begin
              r_state     <= S_OVER;
              o_game_over <= 1'b1;
              o_winner    <= 1'b1;
            end else begin
`ifdef BONUS_TURN_EN
              r_state <= S_WAIT_PC;
`else
              r_state <= S_WAIT_P;
              o_turn  <= 1'b0;
`endif
            end
          end else begin
            if (r_cell == c_water) r_pb[w_shot_idx] <= c_miss;
            r_state <= S_WAIT_P;
            o_turn  <= 1'b0;
          end
        end
        S_OVER: r_state <= S_OVER;
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shot_arbiter.sv
`default_nettype none
// ============================================================================
// tb_shot_arbiter : directed self-checking bench for shot_arbiter (5x5 boards)
// Revision: 1.0
// ============================================================================
module tb_shot_arbiter;

  logic       clk;
  logic       rst;
  logic       place_we, place_board, start;
  logic [2:0] place_row, place_col;
  logic       p_req, pc_req, turn_expired;
  logic [2:0] p_row, p_col, pc_row, pc_col;
  logic       p_ack, pc_ack, res_valid, res_hit, res_repeat, res_err, res_who, turn;
  logic [4:0] p_left, pc_left;
  logic       game_over, winner;
  logic       disp_board;
  logic [2:0] disp_row, disp_col;
  logic [1:0] disp_cell;

  int n_cmp = 0;
  int n_err = 0;
  logic bonus;

  shot_arbiter #(.ROWS(5), .COLS(5)) dut (
    .clk(clk), .rst(rst),
    .i_place_we(place_we), .i_place_board(place_board),
    .i_place_row(place_row), .i_place_col(place_col),
    .i_start(start),
    .i_p_req(p_req), .i_p_row(p_row), .i_p_col(p_col),
    .i_pc_req(pc_req), .i_pc_row(pc_row), .i_pc_col(pc_col),
    .i_turn_expired(turn_expired),
    .o_p_ack(p_ack), .o_pc_ack(pc_ack), .o_res_valid(res_valid),
    .o_res_hit(res_hit), .o_res_repeat(res_repeat), .o_res_err(res_err),
    .o_res_who(res_who), .o_turn(turn),
    .o_p_left(p_left), .o_pc_left(pc_left),
    .o_game_over(game_over), .o_winner(winner),
    .i_disp_board(disp_board), .i_disp_row(disp_row), .i_disp_col(disp_col),
    .o_disp_cell(disp_cell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cell(input string tag, input logic b, input logic [2:0] r,
                          input logic [2:0] c, input logic [1:0] exp);
    disp_board = b;
    disp_row   = r;
    disp_col   = c;
    #1;
    chk(tag, 32'(disp_cell), 32'(exp));
  endtask

  task automatic place(input logic b, input logic [2:0] r, input logic [2:0] c);
    place_we    = 1'b1;
    place_board = b;
    place_row   = r;
    place_col   = c;
    step();
    place_we    = 1'b0;
  endtask

  // Leaves the caller one cycle into WR, where ack and result are visible.
  task automatic shot(input logic who, input logic [2:0] r, input logic [2:0] c);
    if (!who) begin
      p_req = 1'b1; p_row = r; p_col = c;
    end else begin
      pc_req = 1'b1; pc_row = r; pc_col = c;
    end
    step();
    chk("rd_no_ack", 32'({p_ack, pc_ack}), 32'd0);
    step();
  endtask

  task automatic drop();
    p_req  = 1'b0;
    pc_req = 1'b0;
    step();
  endtask

  initial begin
`ifdef BONUS_TURN_EN
    bonus = 1'b1;
`else
    bonus = 1'b0;
`endif
    rst = 1'b1;
    place_we = 0; place_board = 0; place_row = 0; place_col = 0; start = 0;
    p_req = 0; p_row = 0; p_col = 0; pc_req = 0; pc_row = 0; pc_col = 0;
    turn_expired = 0; disp_board = 0; disp_row = 0; disp_col = 0;
    step();
    step();
    chk("rst_p_left",  32'(p_left),  32'd0);
    chk("rst_pc_left", 32'(pc_left), 32'd0);
    chk("rst_turn",    32'(turn),    32'd0);
    chk("rst_acks",    32'({p_ack, pc_ack, res_valid, res_hit, res_repeat, res_err, res_who}), 32'd0);
    chk("rst_over",    32'({game_over, winner}), 32'd0);
    chk_cell("rst_cell", 1'b1, 3'd2, 3'd2, 2'b00);
    rst = 1'b0;
    step();

    // Player ships only; start must be refused
    place(1'b0, 3'd0, 3'd0);
    place(1'b0, 3'd0, 3'd1);
    chk("load_p_left",  32'(p_left),  32'd2);
    chk("load_pc_left", 32'(pc_left), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    p_req = 1'b1; p_row = 3'd4; p_col = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_no_ack", 32'({p_ack, res_valid}), 32'd0);
    end
    p_req = 1'b0;
    chk("load_turn", 32'(turn), 32'd0);

    place(1'b1, 3'd2, 3'd2);
    chk("pc_place", 32'(pc_left), 32'd1);
    place(1'b1, 3'd2, 3'd2);
    chk("pc_replace", 32'(pc_left), 32'd1);
    chk("p_unchanged", 32'(p_left), 32'd2);
    place(1'b1, 3'd5, 3'd0);
    chk("place_oor", 32'(pc_left), 32'd1);
    chk_cell("cell_pc22", 1'b1, 3'd2, 3'd2, 2'b01);
    chk_cell("cell_p01", 1'b0, 3'd0, 3'd1, 2'b01);
    start = 1'b1;
    step();
    start = 1'b0;

    // PC request during the player's turn is ignored
    pc_req = 1'b1; pc_row = 3'd0; pc_col = 3'd0;
    step();
    chk("pc_ignored", 32'(pc_ack), 32'd0);
    chk("wait_p_turn", 32'(turn), 32'd0);
    shot(1'b0, 3'd4, 3'd4);
    chk("miss_ack", 32'({p_ack, res_valid, res_who, pc_ack}), 32'b1100);
    chk("miss_flags", 32'({res_hit, res_repeat, res_err}), 32'd0);
    drop();
    chk("miss_ack_gone", 32'({p_ack, res_valid}), 32'd0);
    chk("miss_turn", 32'(turn), 32'd1);
    chk_cell("miss_cell", 1'b1, 3'd4, 3'd4, 2'b10);

    // PC out-of-range shot keeps the turn
    shot(1'b1, 3'd7, 3'd0);
    chk("err_ack", 32'({pc_ack, res_valid, res_who, p_ack}), 32'b1110);
    chk("err_flags", 32'({res_hit, res_repeat, res_err}), 32'b001);
    drop();
    chk("err_turn", 32'(turn), 32'd1);
    chk("err_p_left", 32'(p_left), 32'd2);

    // PC hits (0,0)
    shot(1'b1, 3'd0, 3'd0);
    chk("phit_flags", 32'({pc_ack, res_hit, res_repeat, res_err}), 32'b1100);
    drop();
    chk("phit_p_left", 32'(p_left), 32'd1);
    chk("phit_turn", 32'(turn), 32'(bonus));
    chk_cell("phit_cell", 1'b0, 3'd0, 3'd0, 2'b11);
    if (bonus) begin
      turn_expired = 1'b1;
      step();
      turn_expired = 1'b0;
    end
    chk("back_to_p", 32'(turn), 32'd0);

    // Timer expiry in WAIT_P hands the turn to the PC
    turn_expired = 1'b1;
    step();
    turn_expired = 1'b0;
    chk("expire_turn", 32'(turn), 32'd1);
    shot(1'b1, 3'd3, 3'd3);
    chk("pmiss_flags", 32'({pc_ack, res_hit, res_repeat, res_err}), 32'b1000);
    drop();
    chk("pmiss_turn", 32'(turn), 32'd0);
    chk_cell("pmiss_cell", 1'b0, 3'd3, 3'd3, 2'b10);

    // Player repeats (4,4)
    shot(1'b0, 3'd4, 3'd4);
    chk("rep_flags", 32'({p_ack, res_hit, res_repeat, res_err}), 32'b1010);
    drop();
    chk("rep_turn", 32'(turn), 32'd1);
    chk("rep_pc_left", 32'(pc_left), 32'd1);
    chk_cell("rep_cell", 1'b1, 3'd4, 3'd4, 2'b10);

    shot(1'b1, 3'd1, 3'd1);
    drop();
    chk("pc_water_turn", 32'(turn), 32'd0);

    // Player sinks the last PC ship
    shot(1'b0, 3'd2, 3'd2);
    chk("win_flags", 32'({p_ack, res_hit, res_who}), 32'b110);
    drop();
    chk("win_pc_left", 32'(pc_left), 32'd0);
    chk("win_over", 32'({game_over, winner}), 32'b10);
    chk_cell("win_cell", 1'b1, 3'd2, 3'd2, 2'b11);

    // Everything is ignored once the game is over
    p_req = 1'b1; p_row = 3'd0; p_col = 3'd0;
    pc_req = 1'b1; pc_row = 3'd1; pc_col = 3'd1;
    place_we = 1'b1; place_board = 1'b1; place_row = 3'd3; place_col = 3'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("over_no_ack", 32'({p_ack, pc_ack, res_valid}), 32'd0);
    end
    p_req = 1'b0; pc_req = 1'b0; place_we = 1'b0;
    chk("over_counts", 32'({pc_left, p_left}), 32'({5'd0, 5'd1}));
    chk("over_hold", 32'({game_over, winner}), 32'b10);
    chk_cell("over_no_place", 1'b1, 3'd3, 3'd3, 2'b00);
    chk_cell("over_no_shot", 1'b1, 3'd0, 3'd0, 2'b00);

    // Reset in the middle of a PC shot
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_over", 32'(game_over), 32'd0);
    place(1'b0, 3'd0, 3'd0);
    place(1'b1, 3'd2, 3'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    turn_expired = 1'b1;
    step();
    turn_expired = 1'b0;
    chk("rst2_turn_pc", 32'(turn), 32'd1);
    pc_req = 1'b1; pc_row = 3'd0; pc_col = 3'd0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_acks", 32'({p_ack, pc_ack, res_valid, res_hit, res_who}), 32'd0);
    chk("mid_counts", 32'({p_left, pc_left}), 32'd0);
    chk("mid_turn_over", 32'({turn, game_over, winner}), 32'd0);
    chk_cell("mid_cell", 1'b0, 3'd0, 3'd0, 2'b00);
    step();
    chk("mid_no_ack", 32'(pc_ack), 32'd0);
    rst = 1'b0;
    pc_req = 1'b0;
    step();
    chk("post_no_ack", 32'({pc_ack, res_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shot_arbiter.md
# shot_arbiter

Turn-sequencing controller for the battleship game, and sole owner of the two board memories. It takes ship placement writes during setup. It arbitrates shot requests from the player input path and the PC opponent in strict turn order, and resolves each shot against the opponent's board. It reports hit, miss or repeat and counts the remaining ship cells. It declares game over and the winner. It sits between the top-level game FSM and the display/LED logic.

## Interface
- ROWS, 5, board rows.
- COLS, 5, board columns.
- RW/CW_, derived: RW=$clog2(ROWS), CLW=$clog2(COLS), NW=$clog2(ROWS*COLS+1).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- place_we  in  1  ship placement write strobe.
- place_board  in  1  0 = player board, 1 = PC board.
- place_row / place_col  in  RW / CLW  placement cell.
- start  in  1  end setup, begin play.
- p_req, p_row, p_col  in  1, RW, CLW  player shot request at the PC board.
- pc_req, pc_row, pc_col  in  1, RW, CLW  PC shot request at the player board.
- turn_expired  in  1  one-cycle pulse from the turn timer.
- p_ack / pc_ack  out  1  one-cycle grant/complete per requester.
- res_valid  out  1  one-cycle result strobe.
- res_hit / res_repeat / res_err  out  1  result flags.
- res_who  out  1  shooter of the result: 0 = player, 1 = PC.
- turn  out  1  whose turn it is: 0 = player, 1 = PC.
- p_left / pc_left  out  NW  remaining un-hit ship cells per board.
- game_over / winner  out  1  game ended; winner 0 = player, 1 = PC.
- disp_board, disp_row, disp_col  in  1, RW, CLW; disp_cell  out  2  combinational display read.

## Operation
- Cell encoding: 00 water, 01 ship, 10 miss, 11 hit.
- States: LOAD, WAIT_P, RD_P, WR_P, WAIT_PC, RD_PC, WR_PC, OVER.
- LOAD handling of place_we:
  - Writes 01 to the addressed cell.
  - The target board's count increments only if the cell was 00.
  - Out-of-range coordinates are ignored.
- place_we is ignored in every state except LOAD.
- LOAD exit: start moves to WAIT_P only if p_left≠0 and pc_left≠0, using the counts before any same-cycle write. Otherwise the block stays in LOAD.
- WAIT_P: turn=0.
  - p_req moves to RD_P; the coordinates are latched.
  - pc_req is ignored and gets no ack.
  - turn_expired without p_req moves to WAIT_PC.
  - When p_req and turn_expired coincide, p_req wins.
- RD_P: reads the PC-board cell into a register.
- WR_P: p_ack=1, res_valid=1, res_who=0. Result by latched cell:
  - Out of range: res_err=1, no board change, return to WAIT_P (shooter retries).
  - Cell 10/11: res_repeat=1, no change, turn passes.
  - Cell 00: write 10, res_hit=0, turn passes.
  - Cell 01: write 11, res_hit=1, pc_left−1.
- Game end: if pc_left reaches 0, go to OVER with winner=0. Otherwise a hit passes the turn (see Configuration).
- The PC path (WAIT_PC/RD_PC/WR_PC) is symmetric: player board, pc_ack, res_who=1, winner=1.
- OVER: game_over=1. All requests and placements are ignored. Only rst leaves this state.
- Requesters hold req and coordinates stable until their ack.
- The ack pulse lasts one cycle. A request still high in the next WAIT state for that requester is a new shot.
- Counts saturate at 0 and never wrap.

## Timing
- Reset values:
  - State LOAD, all cells 00.
  - p_left=pc_left=0, turn=0.
  - All acks and res_* = 0.
  - game_over=0, winner=0.
- Shot latency: req sampled at edge N in WAIT. RD is the cycle after N. ack/res_valid are high in the following cycle (WR). The next WAIT state is entered at the edge ending WR.
- The cell update and count decrement are visible at the edge ending WR.
- game_over rises at that same edge.
- disp_cell is combinational. It reflects each write the cycle after that write's edge.
- rst mid-shot (RD/WR): the block returns to LOAD immediately and clears the boards. The pending ack is not issued.

## Configuration
- BONUS_TURN_EN defined: a hit that does not end the game keeps the turn. The next state is the same shooter's WAIT.
- BONUS_TURN_EN undefined: every non-error result alternates the turn. res_err always keeps the turn in both builds.

## Test plan
- Reset, then place player (0,0),(0,1) and PC (2,2). Placing PC (2,2) again leaves pc_left=1, p_left=2. start moves to WAIT_P.
- start with pc_left=0 -> stays in LOAD, turn=0, no acks.
- Player shoots (4,4) on water:
  - p_ack and res_valid two cycles after the req edge, res_hit=0.
  - Cell reads 10 and turn=1.
  - A pc_req held during the player's turn receives no ack.
- Player shoots (2,2) -> res_hit=1, pc_left 1→0, game_over=1, winner=0. Further reqs are ignored.
- Player shoots (4,4) twice across turns -> second result res_repeat=1, board unchanged. PC shoots (7,0) -> res_err=1, turn stays 1.
- PC hits (0,0):
  - With BONUS_TURN_EN, turn stays 1.
  - Without it, turn becomes 0.
  - In both builds p_left=1.
- turn_expired in WAIT_P passes the turn to the PC. Assert rst during RD_PC -> no pc_ack, all outputs at reset values.
